// File: rtl/seg7_pkg.sv
// Shared segment encodings for the signed-digit 7-segment display interface.
package seg7_pkg;

  // Active-low segments, bit order [6]=a ... [0]=g.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [0:7][6:0] SEG_DIGIT = {
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111
  };

  typedef struct packed {
    logic [6:0] sign;
    logic [6:0] mag;
  } seg_pair_t;

  // Magnitude digit lookup result; mag=8 encodes the blank digit.
  typedef struct packed {
    logic       legal;
    logic [3:0] mag;
  } mag_dec_t;

  // Writer side: two's-complement value -> {sign, mag}; -8 is minus over blank.
  function automatic seg_pair_t seg7_encode(input logic [3:0] value);
    seg_pair_t  pair;
    logic [3:0] abs_v;
    abs_v     = value[3] ? 4'd0 - value : value;
    pair.sign = value[3] ? SEG_MINUS : SEG_DIGIT[0];
    pair.mag  = (abs_v == 4'd8) ? SEG_BLANK : SEG_DIGIT[abs_v[2:0]];
    return pair;
  endfunction

  // Reader side: magnitude digit -> 0..7, blank -> 8, anything else illegal.
  function automatic mag_dec_t seg7_mag_decode(input logic [6:0] mag);
    mag_dec_t dec;
    dec = '{legal: 1'b0, mag: 4'd0};
    if (mag == SEG_BLANK) dec = '{legal: 1'b1, mag: 4'd8};
    for (int i = 0; i < 8; i++) begin
      if (mag == SEG_DIGIT[i]) dec = '{legal: 1'b1, mag: 4'(i)};
    end
    return dec;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a {sign, mag} segment pair to a legal flag and signed value.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [13:0] pair_i,
  output logic        legal_o,
  output logic [3:0]  value_o
);

  seg_pair_t pair;
  mag_dec_t  md;

  assign pair = pair_i;
  assign md   = seg7_mag_decode(pair.mag);

  // Positive excludes blank; negative excludes "0"; the blank magnitude under minus is -8.
  always_comb begin
    legal_o = 1'b0;
    value_o = 4'd0;
    if (md.legal) begin
      if (pair.sign == SEG_DIGIT[0] && md.mag != 4'd8) begin
        legal_o = 1'b1;
        value_o = md.mag;
      end else if (pair.sign == SEG_MINUS && md.mag != 4'd0) begin
        legal_o = 1'b1;
        value_o = 4'd0 - md.mag;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Reader end of the signed-digit 7-segment interface: synchronise, debounce, decode,
// filter repeats and hand values over a valid/ready port.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_mag,
  input  logic [6:0]           seg_sign,
  output logic [3:0]           out_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int unsigned     CntW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntSat  = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntFire = CntW'(STABLE_CYCLES - 1);

  seg_pair_t       sync_q [SYNC_STAGES];
  seg_pair_t       s;
  seg_pair_t       p_q;
  seg_pair_t       last_q;
  logic            first_q;
  logic [CntW-1:0] cnt_q;

  logic            dec_legal;
  logic [3:0]      dec_value;
  logic            stable;
  logic            commit;
  logic            accept;
  logic            push;
  logic            pop;
  logic            drop;

  assign s = sync_q[SYNC_STAGES-1];

  seg7_pattern_decode u_decode (
    .pair_i  (s),
    .legal_o (dec_legal),
    .value_o (dec_value)
  );

  // cnt sits at STABLE_CYCLES once past the fire point, so a held pattern commits only once.
  assign stable    = (s == p_q);
  assign commit    = stable && (cnt_q == CntFire);
  assign accept    = commit && (first_q || (s != last_q));
  assign push      = accept && dec_legal;
  assign err_pulse = accept && !dec_legal;
  assign pop       = out_valid && out_ready;
  assign drop      = push && out_valid && !out_ready;

  // Synchroniser chain on all 14 segment lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= '{sign: seg_sign, mag: seg_mag};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Previous synced sample and saturating stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      p_q <= s;
      if (!stable) begin
        cnt_q <= '0;
      end else if (cnt_q != CntSat) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Last-committed pattern; the first commit after reset always passes the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= '0;
      first_q <= 1'b1;
    end else if (accept) begin
      last_q  <= s;
      first_q <= 1'b0;
    end
  end

  // Single-entry output register; a push while full and not popping is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_value <= 4'd0;
      out_valid <= 1'b0;
    end else if (push && (!out_valid || out_ready)) begin
      out_value <= dec_value;
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Saturating count of illegal commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_pulse && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: run-length reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_seg7_reader;

  localparam int SYNC = 2;
  localparam int STAB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_mag;
  logic [6:0] seg_sign;
  logic [3:0] out_value;
  logic       out_valid;
  logic       out_ready;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_reader #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STAB),
    .ERR_CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_mag   (seg_mag),
    .seg_sign  (seg_sign),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // ---------------- reference model ----------------
  logic [13:0] pipe [$];
  logic [13:0] rv;
  int          rl;
  bit          have_last;
  logic [13:0] last;
  bit          m_valid;
  logic [3:0]  m_value;
  bit          m_ovf;
  int          m_ecnt;

  logic [3:0]  got [$];
  int          errp_seen = 0;

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] enc(input int v);
    if (v >= 0) return {dig(0), dig(v)};
    if (v == -8) return {7'b1111110, 7'b1111111};
    return {7'b1111110, dig(-v)};
  endfunction

  function automatic void mdl_decode(input logic [13:0] pat, output bit lg,
                                     output logic [3:0] val);
    int m;
    m = -1;
    for (int d = 0; d < 8; d++) if (pat[6:0] == dig(d)) m = d;
    if (pat[6:0] == 7'b1111111) m = 8;
    lg  = 1'b0;
    val = 4'd0;
    if (m < 0) return;
    if (pat[13:7] == dig(0) && m <= 7) begin
      lg  = 1'b1;
      val = 4'(m);
    end else if (pat[13:7] == 7'b1111110 && m >= 1) begin
      lg  = 1'b1;
      val = 4'(16 - m);
    end
  endfunction

  // A pattern commits in the cycle its synced run of equal samples reaches STAB+1.
  function automatic bit mdl_accept();
    return (rl == STAB + 1) && (!have_last || rv != last);
  endfunction

  function automatic bit mdl_err();
    bit         lg;
    logic [3:0] vv;
    mdl_decode(rv, lg, vv);
    return mdl_accept() && !lg;
  endfunction

  task automatic mdl_reset();
    pipe.delete();
    for (int i = 0; i < SYNC - 1; i++) pipe.push_back(14'd0);
    rv        = 14'd0;
    rl        = 2;
    have_last = 1'b0;
    last      = 14'd0;
    m_valid   = 1'b0;
    m_value   = 4'd0;
    m_ovf     = 1'b0;
    m_ecnt    = 0;
  endtask

  task automatic mdl_step();
    bit          lg;
    bit          pushed;
    bit          ovf_set;
    logic [3:0]  vv;
    logic [13:0] v;
    pushed  = 1'b0;
    ovf_set = 1'b0;
    vv      = 4'd0;
    if (mdl_accept()) begin
      have_last = 1'b1;
      last      = rv;
      mdl_decode(rv, lg, vv);
      if (!lg) begin
        if (m_ecnt < 255) m_ecnt++;
      end else begin
        pushed = 1'b1;
      end
    end
    if (pushed) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1;
        m_value = vv;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    pipe.push_back({seg_sign, seg_mag});
    v = pipe.pop_front();
    if (v == rv) begin
      if (rl < 1000) rl++;
    end else begin
      rv = v;
      rl = 1;
    end
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl_reset();
      else mdl_step();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) check("cyc_out_value", int'(out_value), int'(m_value));
      check("cyc_overflow", int'(overflow), int'(m_ovf));
      check("cyc_err_cnt", int'(err_cnt), m_ecnt);
      check("cyc_err_pulse", int'(err_pulse), int'(mdl_err()));
      if (out_valid && out_ready) got.push_back(out_value);
      if (err_pulse) errp_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_pins(input logic [13:0] pat);
    seg_sign = pat[13:7];
    seg_mag  = pat[6:0];
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, lat, exp_lat);
  endtask

  initial begin
    int n0;
    int e0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    set_pins(enc(2));
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_value", int'(out_value), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_err_pulse", int'(err_pulse), 0);

    // 1: first value with exact latency, held without duplicates.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_valid("t1_latency", SYNC + STAB + 1);
    check("t1_value", int'(out_value), 2);
    step(20);
    check("t1_still_valid", int'(out_valid), 1);
    check("t1_no_dup_ovf", int'(overflow), 0);
    out_ready = 1'b1;
    step(2);
    check("t1_popped", int'(out_valid), 0);

    // 2: full signed sweep through the writer encoding.
    got.delete();
    for (int v = -8; v <= 7; v++) begin
      set_pins(enc(v));
      step(10);
    end
    check("t2_count", got.size(), 16);
    if (got.size() == 16) begin
      for (int i = 0; i < 16; i++) check("t2_seq", int'(got[i]), (i + 8) % 16);
    end
    check("t2_err_cnt", int'(err_cnt), 0);

    // 3: illegal pairs.
    e0 = errp_seen;
    set_pins({7'b1111110, 7'b0000001});
    step(10);
    check("t3_pulses", errp_seen - e0, 1);
    check("t3_err_cnt", int'(err_cnt), 1);
    check("t3_no_valid", int'(out_valid), 0);
    set_pins({7'b0000001, 7'b1111111});
    step(10);
    check("t3_err_cnt2", int'(err_cnt), 2);

    // 4: short glitch and re-held pattern produce nothing.
    set_pins(enc(3));
    step(10);
    n0 = got.size();
    e0 = errp_seen;
    set_pins(enc(7));
    step(3);
    set_pins(enc(3));
    step(15);
    check("t4_no_xfer", got.size(), n0);
    check("t4_no_err", errp_seen, e0);

    // 5: overflow, clear, and push coinciding with pop.
    out_ready = 1'b0;
    set_pins(enc(1));
    step(10);
    set_pins(enc(5));
    step(10);
    check("t5_kept", int'(out_value), 1);
    check("t5_ovf", int'(overflow), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t5_ovf_clr", int'(overflow), 0);
    set_pins(enc(6));
    repeat (SYNC + STAB) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t5_pp_valid", int'(out_valid), 1);
    check("t5_pp_value", int'(out_value), 6);
    check("t5_pp_ovf", int'(overflow), 0);

    // 6: reset mid-stabilisation with a held value, then recommit.
    step(1);
    set_pins(enc(4));
    step(3);
    rst_n = 1'b0;
    #1;
    check("t6_valid", int'(out_valid), 0);
    check("t6_value", int'(out_value), 0);
    check("t6_err_cnt", int'(err_cnt), 0);
    check("t6_ovf", int'(overflow), 0);
    check("t6_err_pulse", int'(err_pulse), 0);
    step(2);
    rst_n = 1'b1;
    wait_valid("t6_latency", SYNC + STAB + 1);
    check("t6_recommit", int'(out_value), 4);
    // All-zero pins match the cleared last-committed register; first commit still counts.
    rst_n = 1'b0;
    set_pins(14'd0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("t6_first_commit_err", int'(err_cnt), 1);

    // Randomized phase.
    for (int it = 0; it < 250; it++) begin
      int r;
      int hold;
      r = $urandom_range(0, 9);
      if (r < 7) set_pins(enc($urandom_range(0, 15) - 8));
      else set_pins(14'($urandom));
      hold = $urandom_range(1, 10);
      repeat (hold) begin
        @(negedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
        ovf_clr   = ($urandom_range(0, 15) == 0);
      end
    end
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
